// File: rtl/block_tile_sequencer.sv
// rtl/block_tile_sequencer.sv - row-major J x K tile origin sequencer with valid/ready hand-off
//
// Purpose: walks a num_rows x num_cols matrix in J x K tiles. Each tile origin is
// strobed to the extractor (get_start + start_row/start_col). The extracted tile is
// then held for the consumer (blk_valid/blk_ready) until it is accepted.
//
// Ports:
//   clk, rst              clock; asynchronous active-high reset
//   start                 begin a pass (honoured only when idle)
//   num_rows, num_cols    matrix dimensions, latched on an accepted start
//   get_start             one-cycle extractor start strobe
//   start_row, start_col  current tile origin
//   blk_valid, blk_ready  tile hand-off to the consumer
//   busy                  pass in progress
//   done                  one-cycle end-of-pass pulse
//   tile_count            tiles accepted in the current or last pass
module block_tile_sequencer #(
  parameter int J     = 2,
  parameter int K     = 2,
  parameter int DIM_W = 10,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [DIM_W-1:0] num_rows,
  input  logic [DIM_W-1:0] num_cols,
  output logic             get_start,
  output logic [DIM_W-1:0] start_row,
  output logic [DIM_W-1:0] start_col,
  output logic             blk_valid,
  input  logic             blk_ready,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] tile_count
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_HOLD,
    S_DONE
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [DIM_W-1:0] r_rows;
  logic [DIM_W-1:0] r_cols;
  logic [DIM_W-1:0] r_row;
  logic [DIM_W-1:0] r_col;
  logic [CNT_W-1:0] r_count;

  // One extra bit so origin + stride never wraps before the compare.
  logic [DIM_W:0]   w_col_end;
  logic [DIM_W:0]   w_row_end;
  logic             w_col_last;
  logic             w_row_last;
  logic             w_last;
  logic             w_zero;

  assign w_col_end  = {1'b0, r_col} + (DIM_W+1)'(K);
  assign w_row_end  = {1'b0, r_row} + (DIM_W+1)'(J);
  assign w_col_last = (w_col_end >= {1'b0, r_cols});
  assign w_row_last = (w_row_end >= {1'b0, r_rows});
  assign w_last     = w_col_last && w_row_last;
  assign w_zero     = (num_rows == '0) || (num_cols == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_next = w_zero ? S_DONE : S_ISSUE;
        end
      end
      S_ISSUE: w_next = S_HOLD;
      S_HOLD: begin
        if (blk_ready) begin
          w_next = w_last ? S_DONE : S_ISSUE;
        end
      end
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rows  <= '0;
      r_cols  <= '0;
      r_row   <= '0;
      r_col   <= '0;
      r_count <= '0;
    end else begin
      if (r_state == S_IDLE && start) begin
        r_rows  <= num_rows;
        r_cols  <= num_cols;
        r_row   <= '0;
        r_col   <= '0;
        r_count <= '0;
      end else if (r_state == S_HOLD && blk_ready) begin
        r_count <= r_count + 1'b1;
        // The last tile's origin is left in place so it stays visible after the pass.
        if (!w_last) begin
          if (!w_col_last) begin
            r_col <= w_col_end[DIM_W-1:0];
          end else begin
            r_col <= '0;
            r_row <= w_row_end[DIM_W-1:0];
          end
        end
      end
    end
  end

  assign get_start  = (r_state == S_ISSUE);
  assign blk_valid  = (r_state == S_HOLD);
  assign done       = (r_state == S_DONE);
  assign busy       = (r_state != S_IDLE);
  assign start_row  = r_row;
  assign start_col  = r_col;
  assign tile_count = r_count;

endmodule

// File: tb/tb_block_tile_sequencer.sv
// tb/tb_block_tile_sequencer.sv - self-checking bench for block_tile_sequencer
module tb_block_tile_sequencer;

  localparam int J     = 2;
  localparam int K     = 2;
  localparam int DIM_W = 10;
  localparam int CNT_W = 16;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [DIM_W-1:0] num_rows;
  logic [DIM_W-1:0] num_cols;
  logic             get_start;
  logic [DIM_W-1:0] start_row;
  logic [DIM_W-1:0] start_col;
  logic             blk_valid;
  logic             blk_ready;
  logic             busy;
  logic             done;
  logic [CNT_W-1:0] tile_count;

  block_tile_sequencer #(.J(J), .K(K), .DIM_W(DIM_W), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .num_rows   (num_rows),
    .num_cols   (num_cols),
    .get_start  (get_start),
    .start_row  (start_row),
    .start_col  (start_col),
    .blk_valid  (blk_valid),
    .blk_ready  (blk_ready),
    .busy       (busy),
    .done       (done),
    .tile_count (tile_count)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;
  int cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Model: expected tile origins for the pass, in row-major order.
  int exp_r[$];
  int exp_c[$];
  int exp_total;
  int last_r, last_c;
  int m_acc, gs_seen, done_seen;
  int gs_cyc_first, gs_cyc_last, hs_cyc, done_cyc;
  bit chk_en = 1'b0;

  always @(negedge clk) begin
    if (chk_en) begin
      chk("busy_vs_phase", busy, int'(get_start | blk_valid | done));
      if (get_start) begin
        gs_seen++;
        gs_cyc_last = cyc;
        if (gs_seen == 1) gs_cyc_first = cyc;
        chk("gs_excl_valid", blk_valid, 0);
        if (exp_r.size() == 0) begin
          chk("unexpected_get_start", 1, 0);
        end else begin
          last_r = exp_r.pop_front();
          last_c = exp_c.pop_front();
          chk("origin_row", start_row, last_r);
          chk("origin_col", start_col, last_c);
        end
      end
      if (blk_valid) begin
        chk("hold_row", start_row, last_r);
        chk("hold_col", start_col, last_c);
        chk("hold_count", tile_count, m_acc);
        if (blk_ready) begin
          m_acc++;
          hs_cyc = cyc;
        end
      end
      if (done) begin
        done_seen++;
        done_cyc = cyc;
        chk("done_left_tiles", exp_r.size(), 0);
        chk("done_count", tile_count, exp_total);
      end
    end
  end

  task automatic build_model(input int R, input int C);
    exp_r.delete();
    exp_c.delete();
    for (int r = 0; r < R; r += J)
      for (int c = 0; c < C; c += K) begin
        exp_r.push_back(r);
        exp_c.push_back(c);
      end
    exp_total = ((R + J - 1) / J) * ((C + K - 1) / K);
    m_acc = 0; gs_seen = 0; done_seen = 0;
    last_r = 0; last_c = 0;
  endtask

  task automatic run_pass(input int R, input int C, input int stall_idx, input int stall_n,
                          input bit extra, input int exp_lit, input int fin_r, input int fin_c);
    int s_cyc;
    int k;
    int left;
    int stalled;
    bit ex;
    build_model(R, C);
    chk("model_tiles", exp_r.size(), exp_lit);
    left = stall_n; stalled = 0; ex = extra; k = 0;
    @(posedge clk); #1;
    start = 1'b1; num_rows = DIM_W'(R); num_cols = DIM_W'(C); s_cyc = cyc;
    @(posedge clk); #1;
    start = 1'b0; num_rows = 7; num_cols = 9;
    while (done_seen == 0 && k < 200) begin
      if (blk_valid && gs_seen == stall_idx + 1 && left > 0) begin
        blk_ready = 1'b0; left--; stalled++;
      end else begin
        blk_ready = 1'b1;
      end
      if (ex && blk_valid) begin
        start = 1'b1; num_rows = 8; num_cols = 8; ex = 1'b0;
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
      k++;
    end
    start = 1'b0; blk_ready = 1'b1;
    if (k >= 200) chk("pass_timeout", k, 0);
    repeat (3) @(posedge clk);
    #1;
    chk("done_pulses", done_seen, 1);
    chk("idle_busy", busy, 0);
    chk("gs_total", gs_seen, exp_lit);
    chk("stall_cycles", stalled, stall_n);
    chk("final_count", tile_count, exp_lit);
    chk("final_row", start_row, fin_r);
    chk("final_col", start_col, fin_c);
    if (exp_lit == 0) begin
      chk("zero_done_lat", done_cyc - s_cyc, 1);
    end else if (stall_n == 0) begin
      chk("gs_latency", gs_cyc_first - s_cyc, 1);
      chk("gs_spacing", gs_cyc_last - gs_cyc_first, 2 * (exp_lit - 1));
      chk("done_after_hs", done_cyc - hs_cyc, 1);
    end
  endtask

  initial begin
    int k;
    rst = 1'b1; start = 1'b0; blk_ready = 1'b1; num_rows = '0; num_cols = '0;
    #1;
    chk("rst_get_start", get_start, 0);
    chk("rst_blk_valid", blk_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_count", tile_count, 0);
    chk("rst_row", start_row, 0);
    chk("rst_col", start_col, 0);
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    chk_en = 1'b1;

    run_pass(4, 4, -1, 0, 1'b0, 4, 2, 2);
    run_pass(3, 5, -1, 0, 1'b0, 6, 2, 4);
    run_pass(4, 4,  1, 5, 1'b0, 4, 2, 2);
    run_pass(0, 4, -1, 0, 1'b0, 0, 0, 0);
    run_pass(4, 0, -1, 0, 1'b0, 0, 0, 0);
    run_pass(4, 4, -1, 0, 1'b1, 4, 2, 2);

    // Abort a pass with an asynchronous reset while a tile is held.
    build_model(4, 4);
    @(posedge clk); #1;
    start = 1'b1; num_rows = 4; num_cols = 4;
    @(posedge clk); #1;
    start = 1'b0;
    k = 0;
    while (!(blk_valid && gs_seen == 2) && k < 50) begin
      @(posedge clk); #1;
      k++;
    end
    if (k >= 50) chk("abort_timeout", k, 0);
    @(negedge clk); #2;
    chk_en = 1'b0;
    rst = 1'b1;
    #1;
    chk("abort_get_start", get_start, 0);
    chk("abort_blk_valid", blk_valid, 0);
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_count", tile_count, 0);
    chk("abort_row", start_row, 0);
    chk("abort_col", start_col, 0);
    #1 rst = 1'b0;
    build_model(0, 0);
    chk_en = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("abort_no_done", done_seen, 0);
    run_pass(2, 2, -1, 0, 1'b0, 1, 0, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
